// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures cycle distance between pulse events
// and offers each result through a one-deep valid/ready output register.
module period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             period_ovf,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             dropped
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next;
  logic             result_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (state == IDLE && pulse) begin
      state_next = MEASURE;
    end
  end

  // count_r holds the number of cycles since the last event, so sampling it
  // on the next event yields the event-to-event distance directly.
  always_comb begin
    count_next  = count_r;
    result_fire = 1'b0;
    if (clear) begin
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          count_next = pulse ? COUNT_ONE : '0;
        end
        MEASURE: begin
          if (pulse) begin
            result_fire = 1'b1;
            count_next  = COUNT_ONE;
          end else if (count_r != COUNT_MAX) begin
            count_next = count_r + COUNT_ONE;
          end
        end
        default: begin
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_next;
    end
  end

  // A held, unaccepted result wins over a newer one; the loss is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period       <= '0;
      period_ovf   <= 1'b0;
      period_valid <= 1'b0;
      dropped      <= 1'b0;
    end else if (clear) begin
      period_valid <= 1'b0;
      dropped      <= 1'b0;
    end else if (result_fire) begin
      if (!period_valid || period_ready) begin
        period       <= count_r;
        period_ovf   <= (count_r == COUNT_MAX);
        period_valid <= 1'b1;
      end else begin
        dropped <= 1'b1;
      end
    end else if (period_valid && period_ready) begin
      period_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter (WIDTH=16 and WIDTH=4 instances).
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        period_ready = 1'b1;
  logic        pulse_a = 1'b0;
  logic        pulse_b = 1'b0;
  logic [15:0] period_a;
  logic        ovf_a, valid_a, dropped_a;
  logic [3:0]  period_b;
  logic        ovf_b, valid_b, dropped_b;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [16:0] q_a[$];
  logic [4:0]  q_b[$];
  bit          ref_a, ref_b, drop_a;
  int          last_a, last_b;

  period_meter #(.WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .pulse(pulse_a),
    .period(period_a), .period_ovf(ovf_a), .period_valid(valid_a),
    .period_ready(period_ready), .dropped(dropped_a)
  );

  period_meter #(.WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .pulse(pulse_b),
    .period(period_b), .period_ovf(ovf_b), .period_valid(valid_b),
    .period_ready(period_ready), .dropped(dropped_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && !clear && valid_a && period_ready) begin
      logic [16:0] e;
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL sb_a_unexpected: got period=%0d ovf=%0d, no result expected", period_a, ovf_a);
      end else begin
        e = q_a.pop_front();
        if ({ovf_a, period_a} !== e) begin
          bad++;
          $display("FAIL sb_a_result: got period=%0d ovf=%0d want period=%0d ovf=%0d",
                   period_a, ovf_a, e[15:0], e[16]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !clear && valid_b && period_ready) begin
      logic [4:0] e;
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL sb_b_unexpected: got period=%0d ovf=%0d, no result expected", period_b, ovf_b);
      end else begin
        e = q_b.pop_front();
        if ({ovf_b, period_b} !== e) begin
          bad++;
          $display("FAIL sb_b_result: got period=%0d ovf=%0d want period=%0d ovf=%0d",
                   period_b, ovf_b, e[3:0], e[4]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_restart();
    ref_a = 0;
    ref_b = 0;
    drop_a = 0;
    q_a.delete();
    q_b.delete();
  endtask

  task automatic fire_a();
    int d;
    pulse_a = 1'b1;
    if (!ref_a) begin
      ref_a = 1;
    end else begin
      d = cyc - last_a;
      if (q_a.size() != 0 && !period_ready) drop_a = 1;
      else q_a.push_back({(d >= 65535), 16'((d > 65535) ? 65535 : d)});
    end
    last_a = cyc;
    tick();
    pulse_a = 1'b0;
  endtask

  task automatic fire_b();
    int d;
    pulse_b = 1'b1;
    if (!ref_b) begin
      ref_b = 1;
    end else begin
      d = cyc - last_b;
      if (q_b.size() == 0 || period_ready) q_b.push_back({(d >= 15), 4'((d > 15) ? 15 : d)});
    end
    last_b = cyc;
    tick();
    pulse_b = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_restart();
    tick();
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({period_a, ovf_a, valid_a, dropped_a} !== 19'd0) begin
      bad++;
      $display("FAIL %s_a: got period=%0d ovf=%0d valid=%0d dropped=%0d want all 0",
               tag, period_a, ovf_a, valid_a, dropped_a);
    end
    total++;
    if ({period_b, ovf_b, valid_b, dropped_b} !== 7'd0) begin
      bad++;
      $display("FAIL %s_b: got period=%0d ovf=%0d valid=%0d dropped=%0d want all 0",
               tag, period_b, ovf_b, valid_b, dropped_b);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset");
    model_restart();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check_all_zero("reset_idle");
  endtask

  task automatic test_periodic();
    period_ready = 1'b1;
    fire_a();
    idle(3);
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL periodic_ref_only: got valid=%0d want 0", valid_a);
    end
    for (int i = 0; i < 4; i++) begin
      fire_a();
      total++;
      if (valid_a !== 1'b1 || period_a !== 16'd4 || ovf_a !== 1'b0) begin
        bad++;
        $display("FAIL periodic_%0d: got valid=%0d period=%0d ovf=%0d want 1/4/0",
                 i, valid_a, period_a, ovf_a);
      end
      if (i < 3) idle(3);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    fire_a();
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd1) begin
      bad++;
      $display("FAIL b2b_first: got valid=%0d period=%0d want 1/1", valid_a, period_a);
    end
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd1) begin
      bad++;
      $display("FAIL b2b_second: got valid=%0d period=%0d want 1/1", valid_a, period_a);
    end
    tick();
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got valid=%0d want 0", valid_a);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    fire_b();
    idle(19);
    fire_b();
    total++;
    if (valid_b !== 1'b1 || period_b !== 4'd15 || ovf_b !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf: got valid=%0d period=%0d ovf=%0d want 1/15/1", valid_b, period_b, ovf_b);
    end
    idle(4);
    fire_b();
    total++;
    if (valid_b !== 1'b1 || period_b !== 4'd5 || ovf_b !== 1'b0) begin
      bad++;
      $display("FAIL sat_recover: got valid=%0d period=%0d ovf=%0d want 1/5/0", valid_b, period_b, ovf_b);
    end
    tick();
  endtask

  task automatic test_drop();
    do_clear();
    period_ready = 1'b0;
    fire_a();
    idle(2);
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd3 || dropped_a !== 1'b0) begin
      bad++;
      $display("FAIL drop_first: got valid=%0d period=%0d dropped=%0d want 1/3/0", valid_a, period_a, dropped_a);
    end
    idle(2);
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd3 || dropped_a !== drop_a) begin
      bad++;
      $display("FAIL drop_held: got valid=%0d period=%0d dropped=%0d want 1/3/%0d",
               valid_a, period_a, dropped_a, drop_a);
    end
    period_ready = 1'b1;
    tick();
    period_ready = 1'b0;
    total++;
    if (valid_a !== 1'b0 || dropped_a !== 1'b1) begin
      bad++;
      $display("FAIL drop_accept: got valid=%0d dropped=%0d want 0/1", valid_a, dropped_a);
    end
  endtask

  task automatic test_clear_priority();
    period_ready = 1'b1;
    idle(2);
    clear = 1'b1;
    pulse_a = 1'b1;
    model_restart();
    tick();
    clear = 1'b0;
    pulse_a = 1'b0;
    total++;
    if (valid_a !== 1'b0 || dropped_a !== 1'b0 || period_a !== 16'd3) begin
      bad++;
      $display("FAIL clear_prio: got valid=%0d dropped=%0d period=%0d want 0/0/3", valid_a, dropped_a, period_a);
    end
    fire_a();
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL clear_ref_only: got valid=%0d want 0", valid_a);
    end
    idle(6);
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd7) begin
      bad++;
      $display("FAIL clear_then_7: got valid=%0d period=%0d want 1/7", valid_a, period_a);
    end
    tick();
  endtask

  task automatic test_async_reset();
    period_ready = 1'b0;
    fire_a();
    idle(3);
    fire_a();
    idle(2);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_restart();
    @(posedge clk);
    #1;
    rst = 1'b0;
    period_ready = 1'b1;
    fire_a();
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_ref_only: got valid=%0d want 0", valid_a);
    end
    idle(5);
    fire_a();
    total++;
    if (valid_a !== 1'b1 || period_a !== 16'd6) begin
      bad++;
      $display("FAIL rst_then_6: got valid=%0d period=%0d want 1/6", valid_a, period_a);
    end
    tick();
  endtask

  initial begin
    model_restart();
    test_reset();
    test_periodic();
    test_back_to_back();
    test_saturate();
    test_drop();
    test_clear_priority();
    test_async_reset();
    idle(2);
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got a=%0d b=%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of the period counter and the measured result.
REQ-002 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port clear, input, 1, synchronous restart of measurement, active-high.
REQ-005 SHALL have port pulse, input, 1, event strobe; each cycle sampled high is one event.
REQ-006 SHALL have port period, output, WIDTH, measured event-to-event distance in cycles.
REQ-007 SHALL have port period_ovf, output, 1, set when the reported period saturated.
REQ-008 SHALL have port period_valid, output, 1, period/period_ovf hold a result.
REQ-009 SHALL have port period_ready, input, 1, consumer accepts the result when high with period_valid.
REQ-010 SHALL have port dropped, output, 1, sticky flag: a result was lost because the output register was full.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no reference event yet) and MEASURE (counting since the last event).
REQ-012 SHALL, in IDLE with pulse=1, load count_r=1 and move to MEASURE; no result is produced.
REQ-013 SHALL, in IDLE with pulse=0, hold count_r=0 and stay in IDLE.
REQ-014 SHALL, in MEASURE with pulse=0, increment count_r by 1 per cycle, saturating at 2^WIDTH-1.
REQ-015 SHALL, in MEASURE with pulse=1, produce result period=count_r and period_ovf=(count_r==2^WIDTH-1), then reload count_r=1 and stay in MEASURE.
REQ-016 SHALL make period equal the cycle distance between events: events in cycles t and t+N give period=N (N>=1; back-to-back pulses give 1).
REQ-017 SHALL make a result visible on period/period_valid one cycle after the cycle in which the event was sampled.
REQ-018 SHALL complete a transfer in any cycle with period_valid=1 and period_ready=1, clearing period_valid next cycle unless a new result loads.
REQ-019 SHALL, when a new result arrives while period_valid=1 and period_ready=1, load the new result and keep period_valid=1.
REQ-020 SHALL, when a new result arrives while period_valid=1 and period_ready=0, discard the new result, keep the held result unchanged, and set dropped=1.
REQ-021 SHALL hold period and period_ovf stable while period_valid=1 and period_ready=0.
REQ-022 SHALL keep dropped set until rst or clear.
REQ-023 SHALL, on clear=1, next cycle go to IDLE with count_r=0, period_valid=0, dropped=0; clear SHALL take priority over pulse and period_ready in the same cycle.
REQ-024 SHALL leave period/period_ovf data values unchanged on clear; only period_valid is cleared.
REQ-025 SHALL never signal period_valid without a preceding IDLE-to-MEASURE reference event since the last rst/clear.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, count_r=0, period=0, period_ovf=0, period_valid=0, dropped=0, independent of clk.
REQ-027 SHALL, on rst asserted mid-measurement, discard the partial count; the first pulse after rst release is a reference event only.

Verification
REQ-028 SHALL cover: WIDTH=16, period_ready=1, pulses every 4 cycles (a timer loaded with cycles=3) -> first result one cycle after second pulse, period=4, period_ovf=0, repeated for each later pulse.
REQ-029 SHALL cover: pulse high on 3 consecutive cycles from IDLE -> two results, both period=1, period_valid high on 2 consecutive cycles.
REQ-030 SHALL cover: WIDTH=4, pulses 20 cycles apart -> period=15, period_ovf=1; next pulse 5 cycles later -> period=5, period_ovf=0.
REQ-031 SHALL cover: period_ready=0, pulses every 3 cycles -> first result period=3 held, dropped=1 after the next event; raising period_ready for one cycle drops period_valid next cycle.
REQ-032 SHALL cover: clear asserted in the same cycle as a pulse in MEASURE -> no result, state IDLE, dropped=0; next pulse is a reference only, and a following pulse 7 cycles later gives period=7.
REQ-033 SHALL cover: rst asserted asynchronously mid-count with period_valid=1 -> all outputs 0 immediately; after release, two pulses 6 cycles apart give period=6.
